tc_timer: RTL



---
 rtl/tc_timer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped down-counting timer with level IRQ to CP0.
// Registers: 0 CTRL {S[11:4] (prescale build only), IM[3], MODE[2:1], EN[0]},
//            1 PRESET (R/W), 2 COUNT (RO), 3 unused (reads 0).
// Ports: clk, reset (async, active-high), Addr[31:2] (only [3:2] decoded),
//        WE, Din[31:0], Dout[31:0] (combinational read), IRQ (= IM & irq flag).
// Optional: define TC_PRESCALE_EN to add an 8-bit prescaler in CTRL[11:4].
module tc_timer #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

`ifdef TC_PRESCALE_EN
    localparam logic [11:0] CTRL_MASK = 12'hfff;
`else
    localparam logic [11:0] CTRL_MASK = 12'h00f;
`endif
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [11:0]      r_ctrl;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_irq_flag;

    logic w_en;
    logic [1:0] w_mode;
    logic w_wr_ctrl;
    logic w_wr_preset;
    logic w_tick;
    logic w_count_gt1;

    // FSM-derived strobes
    logic w_load;
    logic w_dec;
    logic w_expire;
    logic w_int_stop;
    logic w_int_reload;

    // Upper address bits are decoded by the bridge; high Din bits are
    // simply not stored.
    logic w_unused;
    assign w_unused = &{1'b0, Addr[31:4], Din};

    assign w_en        = r_ctrl[0];
    assign w_mode      = r_ctrl[2:1];
    assign w_wr_ctrl   = WE && (Addr[3:2] == 2'd0);
    assign w_wr_preset = WE && (Addr[3:2] == 2'd1);
    assign w_count_gt1 = (r_count > ONE);

`ifdef TC_PRESCALE_EN
    logic [7:0] r_psc;

    // Count step only when the prescaler has reached S; S=0 steps every cycle.
    assign w_tick = (r_psc == r_ctrl[11:4]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psc <= 8'd0;
        end else if (w_load) begin
            r_psc <= 8'd0;
        end else if (r_state == S_CNT && w_en) begin
            if (w_tick) r_psc <= 8'd0;
            else        r_psc <= r_psc + 8'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; EN low in any state returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_en) w_next = S_LOAD;
            S_LOAD: w_next = w_en ? S_CNT : S_IDLE;
            S_CNT: begin
                if (!w_en)                       w_next = S_IDLE;
                else if (w_tick && !w_count_gt1) w_next = S_INT;
            end
            S_INT: begin
                // Mode 1 reloads directly: IDLE would only bounce to LOAD
                // anyway, and skipping it keeps the period at PRESET+2.
                if (w_en && w_mode == 2'd1) w_next = S_LOAD;
                else                        w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output/strobe logic
    always_comb begin
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_expire     = 1'b0;
        w_int_stop   = 1'b0;
        w_int_reload = 1'b0;
        case (r_state)
            S_LOAD: w_load = w_en;
            S_CNT: begin
                w_dec    = w_en && w_tick && w_count_gt1;
                w_expire = w_en && w_tick && !w_count_gt1;
            end
            S_INT: begin
                w_int_reload = w_en && (w_mode == 2'd1);
                w_int_stop   = w_en && (w_mode != 2'd1);
            end
            default: ;
        endcase
    end

    // CTRL: a CPU write is taken whole and overrides the FSM clearing EN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_ctrl <= 12'd0;
        else if (w_wr_ctrl)  r_ctrl <= Din[11:0] & CTRL_MASK;
        else if (w_int_stop) r_ctrl[0] <= 1'b0;
    end

    // PRESET: takes effect only at the next LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_preset <= '0;
        else if (w_wr_preset) r_preset <= Din[WIDTH-1:0];
    end

    // COUNT: floors at 0 through the expire path, never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_count <= '0;
        else if (w_load)   r_count <= r_preset;
        else if (w_dec)    r_count <= r_count - ONE;
        else if (w_expire) r_count <= '0;
    end

    // IRQ flag: any CTRL/PRESET write acknowledges it, beating a new expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           r_irq_flag <= 1'b0;
        else if (w_wr_ctrl || w_wr_preset)   r_irq_flag <= 1'b0;
        else if (w_expire)                   r_irq_flag <= 1'b1;
        else if (w_load || w_int_reload)     r_irq_flag <= 1'b0;
    end

    assign IRQ = r_ctrl[3] & r_irq_flag;

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd0:    Dout = 32'(r_ctrl);
            2'd1:    Dout = 32'(r_preset);
            2'd2:    Dout = 32'(r_count);
            default: Dout = 32'd0;
        endcase
    end

endmodule
